// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, S-box depth and key-byte selection.
package rc4_pkg;

  localparam int unsigned S_DEPTH       = 256;
  // Widest key any RC4 core in this codebase is built for.
  localparam int unsigned MAX_KEY_BYTES = 8;

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    KSA_RD_I,
    KSA_CAP_I,
    KSA_CALC_J,
    KSA_RD_J,
    KSA_CAP_J,
    KSA_WR_I,
    KSA_WR_J,
    PRGA_INC_I,
    PRGA_RD_I,
    PRGA_CAP_I,
    PRGA_CALC_J,
    PRGA_RD_J,
    PRGA_CAP_J,
    PRGA_WR_I,
    PRGA_WR_J,
    PRGA_RD_F,
    PRGA_CAP_F,
    PRGA_STORE,
    DONE
  } rc4_state_e;

  // Key byte 0 is the most significant byte of a num_bytes-wide key.
  function automatic logic [7:0] key_byte(input logic [8*MAX_KEY_BYTES-1:0] key,
                                          input int unsigned num_bytes,
                                          input int unsigned idx);
    logic [8*MAX_KEY_BYTES-1:0] shifted;
    shifted = key >> (8 * (num_bytes - 1 - idx));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/s_memory.sv
// 256x8 single-port RAM with registered read data (read-before-write on a write cycle).
module s_memory (
  input  logic [7:0] address,
  input  logic       clock,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);

  logic [7:0] mem [256];

  // Write port and registered read port share one address.
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/rc4_encrypt_core.sv
// Single-key RC4 encryptor: INIT, KSA and PRGA over a private S-box, XOR with plaintext.
module rc4_encrypt_core
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN   = 32,
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             plaintext  [MSG_LEN-1:0],
  output logic [7:0]             ciphertext [MSG_LEN-1:0],
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  rc4_state_e state_q, state_d;

  logic [7:0]             i_q, j_q, si_q, sj_q, f_q;
  logic [KW-1:0]          k_q;
  logic [KIW-1:0]         kidx_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             pt_q [MSG_LEN-1:0];

  logic [7:0] mem_addr, mem_data, mem_q;
  logic       mem_wren, fsm_wren;

  logic                       accept, i_last, k_last, kidx_last;
  logic [8*MAX_KEY_BYTES-1:0] key_ext;
  logic [7:0]                 kb;

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign i_last    = (i_q == 8'hFF);
  assign k_last    = (k_q == KW'(MSG_LEN - 1));
  assign kidx_last = (kidx_q == KIW'(KEY_BYTES - 1));
  assign key_ext   = (8*MAX_KEY_BYTES)'(key_q);
  assign kb        = key_byte(key_ext, KEY_BYTES, int'(kidx_q));

  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed state sequence per loop iteration.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (accept) state_d = INIT;
      INIT:        if (i_last) state_d = KSA_RD_I;
      KSA_RD_I:    state_d = KSA_CAP_I;
      KSA_CAP_I:   state_d = KSA_CALC_J;
      KSA_CALC_J:  state_d = KSA_RD_J;
      KSA_RD_J:    state_d = KSA_CAP_J;
      KSA_CAP_J:   state_d = KSA_WR_I;
      KSA_WR_I:    state_d = KSA_WR_J;
      KSA_WR_J:    state_d = i_last ? PRGA_INC_I : KSA_RD_I;
      PRGA_INC_I:  state_d = PRGA_RD_I;
      PRGA_RD_I:   state_d = PRGA_CAP_I;
      PRGA_CAP_I:  state_d = PRGA_CALC_J;
      PRGA_CALC_J: state_d = PRGA_RD_J;
      PRGA_RD_J:   state_d = PRGA_CAP_J;
      PRGA_CAP_J:  state_d = PRGA_WR_I;
      PRGA_WR_I:   state_d = PRGA_WR_J;
      PRGA_WR_J:   state_d = PRGA_RD_F;
      PRGA_RD_F:   state_d = PRGA_CAP_F;
      PRGA_CAP_F:  state_d = PRGA_STORE;
      PRGA_STORE:  state_d = k_last ? DONE : PRGA_INC_I;
      DONE:        if (accept) state_d = INIT;
      default:     state_d = IDLE;
    endcase
  end

  // S-box port: address/data/write-enable decoded from the current state.
  always_comb begin
    mem_addr = i_q;
    mem_data = i_q;
    fsm_wren = 1'b0;
    unique case (state_q)
      INIT: fsm_wren = 1'b1;
      KSA_RD_J, KSA_CAP_J, PRGA_RD_J, PRGA_CAP_J: mem_addr = j_q;
      KSA_WR_I, PRGA_WR_I: begin
        mem_data = sj_q;
        fsm_wren = 1'b1;
      end
      KSA_WR_J, PRGA_WR_J: begin
        mem_addr = j_q;
        mem_data = si_q;
        fsm_wren = 1'b1;
      end
      PRGA_RD_F, PRGA_CAP_F: mem_addr = si_q + sj_q;
      default: ;
    endcase
  end

  // A reset cycle must never disturb the S-box, even mid-write.
  assign mem_wren = fsm_wren && !reset;

  s_memory s_mem (
    .address (mem_addr),
    .clock   (CLOCK_50),
    .data    (mem_data),
    .wren    (mem_wren),
    .q       (mem_q)
  );

  // Datapath: counters, captured S-box values, latched inputs and ciphertext.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      kidx_q <= '0;
      si_q   <= '0;
      sj_q   <= '0;
      f_q    <= '0;
      for (int n = 0; n < MSG_LEN; n++) begin
        ciphertext[n] <= '0;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            key_q  <= secret_key;
            pt_q   <= plaintext;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            kidx_q <= '0;
          end
        end
        INIT: begin
          i_q <= i_q + 8'd1;
          if (i_last) begin
            j_q    <= '0;
            kidx_q <= '0;
          end
        end
        KSA_CAP_I:  si_q <= mem_q;
        KSA_CALC_J: j_q  <= j_q + si_q + kb;
        KSA_CAP_J:  sj_q <= mem_q;
        KSA_WR_J: begin
          if (i_last) begin
            // PRGA starts from i = j = 0.
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
          end else begin
            i_q    <= i_q + 8'd1;
            kidx_q <= kidx_last ? '0 : kidx_q + KIW'(1);
          end
        end
        PRGA_INC_I:  i_q  <= i_q + 8'd1;
        PRGA_CAP_I:  si_q <= mem_q;
        PRGA_CALC_J: j_q  <= j_q + si_q;
        PRGA_CAP_J:  sj_q <= mem_q;
        PRGA_CAP_F:  f_q  <= mem_q;
        PRGA_STORE: begin
          ciphertext[k_q] <= f_q ^ pt_q[k_q];
          if (!k_last) begin
            k_q <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Directed bench for rc4_encrypt_core with a software RC4 reference.
module tb_rc4_encrypt_core;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  pt_in  [31:0];
  logic [7:0]  ct_out [31:0];
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] kv_exp [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] kv_pt  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

  always #5 CLOCK_50 = ~CLOCK_50;

  rc4_encrypt_core #(
    .MSG_LEN   (32),
    .KEY_BYTES (3)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .plaintext  (pt_in),
    .ciphertext (ct_out),
    .busy       (busy),
    .done       (done)
  );

  // Reference RC4 for a 3-byte key.
  task automatic rc4_model(input logic [23:0] key, input logic [7:0] pt [31:0],
                           output logic [7:0] ct [31:0]);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t, tmp;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      tmp = s[n]; s[n] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = s[i] + s[j];
      ct[k] = s[t] ^ pt[k];
    end
  endtask

  task automatic set_known_pt();
    for (int n = 0; n < 32; n++) pt_in[n] = (n < 9) ? kv_pt[n] : 8'h00;
  endtask

  // Start pulse of one cycle; returns #1 after the accept edge.
  task automatic start_run(input logic [23:0] key);
    secret_key = key;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; n counts edges from the current point.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 5000) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (ct_out[n] !== 8'h00) begin
        errors++; $display("FAIL reset_ct[%0d]: got %h want 00", n, ct_out[n]);
      end
    end
    reset = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_known_vector();
    int n;
    logic [7:0] exp_ct [31:0];
    set_known_pt();
    rc4_model(24'h4B6579, pt_in, exp_ct);
    start_run(24'h4B6579);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL kv_busy_after_accept: got %b want 1", busy); end
    wait_done(n);
    checks++;
    if (n !== 2400) begin errors++; $display("FAIL kv_latency: got %0d want 2400", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kv_busy_at_done: got %b want 0", busy); end
    for (int b = 0; b < 9; b++) begin
      checks++;
      if (ct_out[b] !== kv_exp[b]) begin
        errors++; $display("FAIL kv_ct[%0d]: got %h want %h", b, ct_out[b], kv_exp[b]);
      end
    end
    for (int b = 9; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== exp_ct[b]) begin
        errors++; $display("FAIL kv_tail[%0d]: got %h want %h", b, ct_out[b], exp_ct[b]);
      end
    end
  endtask

  task automatic test_involution();
    int n;
    logic [7:0] orig [31:0];
    logic [7:0] exp_ct [31:0];
    logic [7:0] ct1 [31:0];
    for (int b = 0; b < 32; b++) orig[b] = 8'($urandom);
    pt_in = orig;
    rc4_model(24'h000249, orig, exp_ct);
    start_run(24'h000249);
    wait_done(n);
    checks++;
    if (n !== 2400) begin errors++; $display("FAIL inv_latency1: got %0d want 2400", n); end
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== exp_ct[b]) begin
        errors++; $display("FAIL inv_enc[%0d]: got %h want %h", b, ct_out[b], exp_ct[b]);
      end
    end
    ct1 = ct_out;
    pt_in = ct1;
    start_run(24'h000249);
    wait_done(n);
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== orig[b]) begin
        errors++; $display("FAIL inv_dec[%0d]: got %h want %h", b, ct_out[b], orig[b]);
      end
    end
  endtask

  task automatic test_reset_mid_ksa();
    set_known_pt();
    start_run(24'h4B6579);
    repeat (999) @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== 8'h00) begin
        errors++; $display("FAIL midrst_ct[%0d]: got %h want 00", b, ct_out[b]);
      end
    end
    reset = 1'b0;
    @(posedge CLOCK_50); #1;
    test_known_vector();
  endtask

  task automatic test_start_while_busy();
    int n;
    logic [7:0] exp_ct [31:0];
    set_known_pt();
    rc4_model(24'h4B6579, pt_in, exp_ct);
    start_run(24'h4B6579);
    repeat (499) @(posedge CLOCK_50);
    #1;
    secret_key = 24'hFFFFFF;
    for (int b = 0; b < 32; b++) pt_in[b] = 8'hA5;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    wait_done(n);
    checks++;
    if (500 + n !== 2400) begin errors++; $display("FAIL swb_latency: got %0d want 2400", 500 + n); end
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== exp_ct[b]) begin
        errors++; $display("FAIL swb_ct[%0d]: got %h want %h", b, ct_out[b], exp_ct[b]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] pt_a [31:0];
    logic [7:0] exp_a [31:0];
    logic [7:0] exp_b [31:0];
    for (int b = 0; b < 32; b++) pt_a[b] = 8'(b * 7 + 3);
    pt_in = pt_a;
    rc4_model(24'h000249, pt_a, exp_a);
    secret_key = 24'h000249;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    wait_done(n);
    checks++;
    if (n !== 2400) begin errors++; $display("FAIL b2b_latency1: got %0d want 2400", n); end
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== exp_a[b]) begin
        errors++; $display("FAIL b2b_ct_a[%0d]: got %h want %h", b, ct_out[b], exp_a[b]);
      end
    end
    // New inputs must be the ones latched by the DONE-state accept.
    secret_key = 24'h4B6579;
    set_known_pt();
    rc4_model(24'h4B6579, pt_in, exp_b);
    @(posedge CLOCK_50); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_done(n);
    start = 1'b0;
    checks++;
    if (n !== 2400) begin errors++; $display("FAIL b2b_latency2: got %0d want 2400", n); end
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== exp_b[b]) begin
        errors++; $display("FAIL b2b_ct_b[%0d]: got %h want %h", b, ct_out[b], exp_b[b]);
      end
    end
    @(posedge CLOCK_50); #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_hold: got %b want 1", done); end
  endtask

  task automatic test_key_wrap();
    int n;
    logic [7:0] exp_ct [31:0];
    for (int b = 0; b < 32; b++) pt_in[b] = 8'h00;
    rc4_model(24'hFFFFFF, pt_in, exp_ct);
    start_run(24'hFFFFFF);
    wait_done(n);
    checks++;
    if (n !== 2400) begin errors++; $display("FAIL wrap_latency: got %0d want 2400", n); end
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (ct_out[b] !== exp_ct[b]) begin
        errors++; $display("FAIL wrap_ct[%0d]: got %h want %h", b, ct_out[b], exp_ct[b]);
      end
    end
  endtask

  initial begin
    for (int b = 0; b < 32; b++) pt_in[b] = 8'h00;
    test_reset();
    test_known_vector();
    test_involution();
    test_reset_mid_ksa();
    test_start_while_busy();
    test_back_to_back();
    test_key_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_encrypt_core.md
Name: rc4_encrypt_core

Overview:
Single-key RC4 encryptor. It is the write-side counterpart of the key-search decryption core. It takes a 24-bit secret key and a MSG_LEN-byte plaintext, runs KSA and PRGA on a private 256x8 s_memory, and returns ciphertext. Test infrastructure uses it to produce ROM images that the decryption cores later crack.

Parameters:
MSG_LEN, 32, number of message bytes processed; legal range 1..256.
KEY_BYTES, 3, key length in bytes; the secret_key width is 8*KEY_BYTES.

Ports:
CLOCK_50  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high; returns the block to IDLE.
start  in  1  level; sampled only in IDLE.
secret_key  in  8*KEY_BYTES  key; key byte 0 = secret_key[23:16], byte 2 = [7:0].
plaintext  in  8 x MSG_LEN (unpacked [MSG_LEN-1:0])  message bytes.
ciphertext  out  8 x MSG_LEN (unpacked)  encrypted bytes; valid while done=1.
busy  out  1  high from the start-accept edge until DONE is entered.
done  out  1  level; high in DONE until the next accepted start or reset.

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE; busy=0, done=0, all ciphertext bytes = 0x00, i=j=k=0.
  - s_memory contents are don't-care.
  - Reset mid-operation aborts immediately; no memory write is issued on the reset cycle or after it.
- Start acceptance:
  - start=1 sampled in IDLE or DONE latches secret_key and plaintext into internal registers and clears done.
  - Later input changes have no effect until the next acceptance.
  - start while busy is ignored.
- s_memory timing: address and wren are driven combinationally from the state, and q is valid in the following state. Every read therefore costs 2 cycles: ADDR, then CAP, which captures q at the end of the cycle.
- INIT: 256 cycles, each writing s[i]=i for i=0..255.
- KSA: 7 cycles per i, for i=0..255; j starts at 0. States in order:
  - RD_I: address i.
  - CAP_I: capture si.
  - CALC_J: j = j + si + key[i mod KEY_BYTES], mod 256.
  - RD_J: address j.
  - CAP_J: capture sj.
  - WR_I: s[i] = sj.
  - WR_J: s[j] = si.
- PRGA: 11 cycles per k, for k=0..MSG_LEN-1; i and j are reset to 0 on entry. States in order:
  - INC_I: i = i+1.
  - RD_I, CAP_I.
  - CALC_J: j = j + si.
  - RD_J, CAP_J.
  - WR_I: s[i] = sj.
  - WR_J: s[j] = si.
  - RD_F: address (si + sj) mod 256.
  - CAP_F.
  - STORE: ciphertext[k] = q ^ plaintext[k], then k = k+1.
- All index arithmetic is 8-bit and wraps mod 256 (i, j, si+sj). i mod KEY_BYTES is kept as a separate 0..KEY_BYTES-1 counter; no divider.
- Latency: with the accept edge at E0, done rises after edge E0 + 256 + 1792 + 11*MSG_LEN (2400 for MSG_LEN=32). busy falls on the same edge.
- State flow: IDLE -> INIT -> KSA -> PRGA -> DONE. DONE returns to INIT on the next accepted start.
- Ciphertext bytes not yet computed hold their previous values; they are reset to 0 only by reset.
- When a loop finishes at i=255 (KSA) or k=MSG_LEN-1 (PRGA), control goes to the next phase; counters never wrap into a second pass.

Decomposition:
- Package rc4_pkg holds:
  - state enum: IDLE, INIT, KSA_*, PRGA_*, DONE;
  - S_DEPTH = 256;
  - the key-byte extraction function key_byte(key, idx).
- The decryption cores share this package.
- s_memory (existing 256x8 single-port IP) is instantiated internally. No new sub-module; the FSM and datapath stay in one file.

Test Plan:
- Known vector:
  - Stimulus: key 0x4B6579 ("Key"), plaintext "Plaintext" zero-padded to 32 bytes.
  - Response: ciphertext[0..8] = BB F3 16 E8 D9 40 AF 0A D3; done rises exactly 2400 cycles after accept.
- Involution: encrypt a random 32-byte message with key 0x000249, then feed the ciphertext back with the same key -> output equals the original plaintext.
- Reset mid-KSA:
  - Stimulus: assert reset at cycle 1000 after accept, then restart with key 0x4B6579.
  - Response: busy=0, done=0 and ciphertext all 0x00 right after reset; the restart gives the known-vector result.
- Start while busy: pulse start with a different key at cycle 500 -> ignored; result matches the first key; done rises at cycle 2400.
- Back-to-back:
  - Stimulus: start held high through DONE.
  - Response: done is high for exactly 1 cycle; the new run latches the current inputs; the second result is correct.
- Key wrap: key 0xFFFFFF, plaintext all 0x00 -> ciphertext equals the raw keystream; matches the reference model, including j wrap-around.
